// File: rtl/rotseq_pkg.sv
// rotseq_pkg: shared op codes, rotator enable codes and FSM states for rotate_sequencer.
package rotseq_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_ROTR = 2'b10,
    OP_ROTL = 2'b11
  } op_e;

  localparam logic [1:0] ENA_HOLD = 2'b00;
  localparam logic [1:0] ENA_R    = 2'b01;
  localparam logic [1:0] ENA_L    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROT,
    S_DONE
  } state_e;

endpackage

// File: rtl/rotseq_step_counter.sv
// rotseq_step_counter: loadable down-counter of remaining steps plus an up-counter of issued steps.
module rotseq_step_counter #(
  parameter int AMT_W = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [AMT_W-1:0] load_val,
  input  logic             step,
  output logic             zero,
  output logic [AMT_W-1:0] steps
);

  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [AMT_W-1:0] steps_q, steps_d;

  always_comb begin
    cnt_d   = load ? load_val : step ? cnt_q - AMT_W'(1) : cnt_q;
    steps_d = load ? '0 : step ? steps_q + AMT_W'(1) : steps_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      steps_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
    end
  end

  assign zero  = cnt_q == '0;
  assign steps = steps_q;

endmodule

// File: rtl/rotate_sequencer.sv
// rotate_sequencer: expands LOAD/ROTATE commands into single-step load/ena cycles for a W-bit rotator.
// The counter holds steps remaining after the current one, so its zero flag marks the final step.
module rotate_sequencer
  import rotseq_pkg::*;
#(
  parameter int W        = 100,
  parameter int AMT_W    = 7,
  parameter int SHORTEST = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amount,
  input  logic [W-1:0]     cmd_data,
  input  logic             abort,
  output logic             rot_load,
  output logic [1:0]       rot_ena,
  output logic [W-1:0]     rot_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] steps_done
);

  localparam logic [AMT_W-1:0] W_A    = AMT_W'(W);
  localparam logic [AMT_W-1:0] HALF_A = AMT_W'(W / 2);

  state_e           state_q, state_d;
  logic             rot_load_q, rot_load_d;
  logic [1:0]       rot_ena_q, rot_ena_d;
  logic [W-1:0]     rot_data_q, rot_data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cnt_load, cnt_step, cnt_zero;
  logic             too_far, flip;
  logic [AMT_W-1:0] k, k_m1;
  logic [1:0]       dir;

  always_comb begin
    too_far = cmd_amount >= W_A;
    flip    = (SHORTEST != 0) && (cmd_amount > HALF_A);
    k       = flip ? W_A - cmd_amount : cmd_amount;
    k_m1    = k - AMT_W'(1);
    dir     = ((cmd_op == OP_ROTR) != flip) ? ENA_R : ENA_L;
  end

  always_comb begin
    state_d    = state_q;
    rot_load_d = 1'b0;
    rot_ena_d  = ENA_HOLD;
    rot_data_d = rot_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cnt_load   = 1'b0;
    cnt_step   = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        cnt_load = 1'b1;
        state_d  = S_DONE;
        done_d   = 1'b1;
        if (cmd_op == OP_LOAD) begin
          state_d    = S_LOAD;
          done_d     = 1'b0;
          rot_load_d = 1'b1;
          rot_data_d = cmd_data;
        end else if (cmd_op[1]) begin
          if (too_far) err_d = 1'b1;
          else if (cmd_amount != '0) begin
            state_d   = S_ROT;
            done_d    = 1'b0;
            rot_ena_d = dir;
          end
        end
      end
      S_LOAD: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_ROT: begin
        cnt_step = 1'b1;
        // The final step wins over abort: that command completes cleanly.
        if (cnt_zero || abort) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = !cnt_zero;
        end else rot_ena_d = rot_ena_q;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      rot_load_q <= 1'b0;
      rot_ena_q  <= ENA_HOLD;
      rot_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rot_load_q <= rot_load_d;
      rot_ena_q  <= rot_ena_d;
      rot_data_q <= rot_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  rotseq_step_counter #(.AMT_W(AMT_W)) u_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (cnt_load),
    .load_val (k_m1),
    .step     (cnt_step),
    .zero     (cnt_zero),
    .steps    (steps_done)
  );

  assign cmd_ready = state_q == S_IDLE;
  assign busy      = !cmd_ready;
  assign rot_load  = rot_load_q;
  assign rot_ena   = rot_ena_q;
  assign rot_data  = rot_data_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// tb_rotate_sequencer: directed bench with a behavioural 100-bit rotator driven by the DUT outputs.
module tb_rotate_sequencer;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [6:0]  cmd_amount = '0;
  logic [99:0] cmd_data = '0;
  logic        abort = 1'b0;
  logic        rot_load;
  logic [1:0]  rot_ena;
  logic [99:0] rot_data;
  logic        busy, done, err;
  logic [6:0]  steps_done;
  logic [99:0] q_m = '0;
  int          checks = 0;
  int          errors = 0;
  rotate_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_amount (cmd_amount),
    .cmd_data   (cmd_data),
    .abort      (abort),
    .rot_load   (rot_load),
    .rot_ena    (rot_ena),
    .rot_data   (rot_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .steps_done (steps_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rot_load) q_m <= rot_data;
    else if (rot_ena == 2'b01) q_m <= {q_m[0], q_m[99:1]};
    else if (rot_ena == 2'b10) q_m <= {q_m[98:0], q_m[99]};
  end
  task automatic chk(input string tag, input logic [99:0] obs, input logic [99:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] op, input logic [6:0] amt, input logic [99:0] d);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_amount = amt;
    cmd_data   = d;
    tick();
    cmd_valid  = 1'b0;
  endtask
  task automatic run_rot(input logic [1:0] op, input logic [6:0] amt, input logic [1:0] e,
                         input int k, input logic [99:0] qx);
    send(op, amt, '0);
    for (int i = 0; i < k; i++) begin
      chk("rot_ena", rot_ena, e);
      chk("rot_load_low", rot_load, 1'b0);
      tick();
    end
    chk("rot_end_ena", rot_ena, 2'b00);
    chk("rot_done", done, 1'b1);
    chk("rot_err", err, 1'b0);
    chk("rot_steps", steps_done, 7'(k));
    chk("rot_q", q_m, qx);
    tick();
    chk("rot_idle", busy, 1'b0);
  endtask
  initial begin
    #3;
    chk("rst_load", rot_load, 1'b0);
    chk("rst_ena", rot_ena, 2'b00);
    chk("rst_data", rot_data, 100'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_steps", steps_done, 7'd0);
    chk("rst_busy", busy, 1'b0);
    tick();
    resetn = 1'b1;
    tick();
    chk("rst_ready", cmd_ready, 1'b1);
    send(2'b01, 7'd0, 100'd1);
    chk("ld_load", rot_load, 1'b1);
    chk("ld_data", rot_data, 100'd1);
    chk("ld_done_early", done, 1'b0);
    chk("ld_busy", busy, 1'b1);
    chk("ld_ready_low", cmd_ready, 1'b0);
    tick();
    chk("ld_load_drop", rot_load, 1'b0);
    chk("ld_done", done, 1'b1);
    chk("ld_err", err, 1'b0);
    tick();
    chk("ld_done_pulse", done, 1'b0);
    chk("ld_q", q_m, 100'd1);
    run_rot(2'b10, 7'd3, 2'b01, 3, 100'd1 << 97);
    run_rot(2'b10, 7'd98, 2'b10, 2, 100'd1 << 99);
    run_rot(2'b10, 7'd50, 2'b01, 50, 100'd1 << 49);
    run_rot(2'b11, 7'd0, 2'b00, 0, 100'd1 << 49);
    run_rot(2'b11, 7'd99, 2'b01, 1, 100'd1 << 48);
    send(2'b11, 7'd100, '0);
    chk("rej_ena", rot_ena, 2'b00);
    chk("rej_done", done, 1'b1);
    chk("rej_err", err, 1'b1);
    chk("rej_steps", steps_done, 7'd0);
    tick();
    chk("rej_err_pulse", err, 1'b0);
    chk("rej_idle", busy, 1'b0);
    send(2'b00, 7'd5, '0);
    chk("nop_done", done, 1'b1);
    chk("nop_err", err, 1'b0);
    chk("nop_steps", steps_done, 7'd0);
    tick();
    send(2'b11, 7'd20, '0);
    for (int i = 0; i < 4; i++) begin
      chk("abt_ena", rot_ena, 2'b10);
      tick();
    end
    chk("abt_ena5", rot_ena, 2'b10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_hold", rot_ena, 2'b00);
    chk("abt_done", done, 1'b1);
    chk("abt_err", err, 1'b1);
    chk("abt_steps", steps_done, 7'd5);
    chk("abt_q", q_m, 100'd1 << 53);
    tick();
    chk("abt_idle", busy, 1'b0);
    send(2'b10, 7'd2, '0);
    chk("abl_ena1", rot_ena, 2'b01);
    tick();
    chk("abl_ena2", rot_ena, 2'b01);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abl_done", done, 1'b1);
    chk("abl_err", err, 1'b0);
    chk("abl_steps", steps_done, 7'd2);
    chk("abl_q", q_m, 100'd1 << 51);
    tick();
    abort = 1'b1;
    send(2'b01, 7'd0, 100'h5);
    chk("idle_abort_load", rot_load, 1'b1);
    tick();
    abort = 1'b0;
    chk("idle_abort_done", done, 1'b1);
    chk("idle_abort_err", err, 1'b0);
    tick();
    send(2'b10, 7'd40, '0);
    for (int i = 0; i < 9; i++) tick();
    chk("rstm_ena10", rot_ena, 2'b01);
    chk("rstm_steps9", steps_done, 7'd9);
    #2;
    resetn = 1'b0;
    #1;
    chk("rstm_ena", rot_ena, 2'b00);
    chk("rstm_busy", busy, 1'b0);
    chk("rstm_data", rot_data, 100'd0);
    chk("rstm_steps", steps_done, 7'd0);
    tick();
    resetn = 1'b1;
    tick();
    chk("rstm_ready", cmd_ready, 1'b1);
    send(2'b01, 7'd0, 100'hABC_DEF0_1234);
    chk("rstm_ld_load", rot_load, 1'b1);
    chk("rstm_ld_data", rot_data, 100'hABC_DEF0_1234);
    tick();
    chk("rstm_ld_done", done, 1'b1);
    tick();
    chk("rstm_ld_q", q_m, 100'hABC_DEF0_1234);
    chk("rstm_ld_idle", busy, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rotate_sequencer.md
Name: rotate_sequencer

Overview:
- Command-driven controller for the 100-bit rotator (ports load, ena[1:0], data, q).
- Accepts LOAD / ROTATE commands over a valid/ready handshake and expands each ROTATE by N into N single-step ena cycles.
- Optionally takes the shorter direction, supports abort, and reports completion and step count.
- Sits between a register/CPU front end and the rotator; the rotator itself is not instantiated here.

Parameters:
- W, 100: rotator width; cmd_data and rot_data width.
- AMT_W, 7: width of cmd_amount and steps_done; must satisfy 2^AMT_W > W.
- SHORTEST, 1: when 1, rotations longer than W/2 are reissued in the opposite direction.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  operation: 00 NOP, 01 LOAD, 10 ROT_R, 11 ROT_L.
- cmd_amount  in  AMT_W  rotate distance in bit positions.
- cmd_data  in  W  load value.
- abort  in  1  stop the current ROTATE after the current step.
- rot_load  out  1  to rotator load.
- rot_ena  out  2  to rotator ena: 01 = right by 1, 10 = left by 1, 00 = hold; 11 is never driven.
- rot_data  out  W  to rotator data; holds the last LOAD value.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse together with done on a rejected or aborted command.
- steps_done  out  AMT_W  single steps issued for the last command; held until the next accept.

Behaviour:
- Reset (async, resetn=0): state IDLE; rot_load=0, rot_ena=00, rot_data=0, done=0, err=0, steps_done=0, busy=0, cmd_ready=1 once reset is released.
- Reset mid-operation takes effect immediately and drops remaining steps. Rotator contents are not our concern.
- All outputs are registered except cmd_ready and busy, which are decoded from the state register.
- Accept occurs at an edge where cmd_valid && cmd_ready. cmd_data and cmd_amount are captured at accept.
- States:
  - IDLE: wait for accept.
  - LOAD: for one cycle.
  - ROTATE: for k cycles.
  - DONE: for one cycle, then back to IDLE.
- NOP: accept -> DONE. In the next cycle done=1 and steps_done=0.
- LOAD accepted at edge t:
  - Cycle t+1: rot_load=1, rot_data=cmd_data.
  - Cycle t+2: done=1, rot_load=0.
- ROTATE with amount a:
  - a >= W: rejected -> DONE with err=1 and no rot_ena activity.
  - a == 0: DONE directly, no ena cycles.
  - SHORTEST=1 and a > W/2 (integer division): direction flipped and k = W - a. Otherwise k = a.
  - a == W/2 keeps the commanded direction.
  - rot_ena holds the direction code for exactly k consecutive cycles starting the cycle after accept.
  - The following cycle has rot_ena=00 and done=1.
  - steps_done increments once per ena cycle.
  - rot_load stays 0 throughout a ROTATE.
- Abort:
  - Sampled only in ROTATE. When abort=1 at an edge, the cycle after that edge has rot_ena=00, done=1, err=1.
  - The ena cycle during which abort was sampled counts as issued.
  - If abort coincides with the final step, the command completes normally with err=0.
  - Abort in IDLE, LOAD or DONE is ignored.
- cmd_valid during busy is not accepted; the requester holds the command stable until cmd_ready.
- Back-to-back throughput is one command per k+2 cycles; a command is accepted in the same edge that DONE returns to IDLE is not possible, since cmd_ready is low in DONE.

Decomposition:
- Package rotseq_pkg holds:
  - op codes (OP_NOP, OP_LOAD, OP_ROTR, OP_ROTL);
  - ena codes (ENA_HOLD=2'b00, ENA_R=2'b01, ENA_L=2'b10);
  - the state enum (S_IDLE, S_LOAD, S_ROT, S_DONE).
- One sub-module, rotseq_step_counter:
  - loadable AMT_W down-counter with a zero flag and an up-counting steps_done;
  - shortest-path computation (compare and subtract) stays in the parent.

Test Plan:
- Reset then LOAD cmd_data=1 -> rot_load high exactly one cycle with rot_data=1, done one cycle later; rotator q=...0001.
- ROT_R amount=3 -> rot_ena=01 for 3 consecutive cycles, then 00 with done=1, steps_done=3; q bit 97 set after LOAD of 1.
- SHORTEST=1, ROT_R amount=98 -> rot_ena=10 for 2 cycles, steps_done=2. Amount=50 -> 01 for 50 cycles.
- ROT_L amount=0 -> no ena cycles, done next cycle. Amount=100 -> done=1, err=1, rot_ena never leaves 00.
- ROT_L amount=20, abort pulsed during 5th ena cycle -> next cycle rot_ena=00, done=err=1, steps_done=5.
- resetn dropped during the 10th step of ROT_R amount=40 -> rot_ena=00 and busy=0 immediately. After release, cmd_ready=1 and a new LOAD completes normally.
